// File: rtl/ce_grad_accum.sv
// Batch-mean cross-entropy gradient accumulator fed by the -1/p reciprocal table.
// Optional macro CE_GRAD_SAT_EN: saturating accumulate with sticky out_sat; otherwise acc wraps.
//
// Handshake rule for both ports: a beat transfers on a rising clk edge where
// valid && ready are both high; valid, once raised, holds with stable data until that edge.
module ce_grad_accum #(
    parameter int BATCH_LOG2 = 3,
    parameter int ACC_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      in_p,
    input  logic             in_y,
    output logic [11:0]      tbl_addr,
    input  logic [12:0]      tbl_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_grad,
    output logic             out_sat
);

    localparam int CNT_W = BATCH_LOG2 + 1;
    localparam logic [CNT_W-1:0] BATCH_N   = CNT_W'(2 ** BATCH_LOG2);
    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(2 ** BATCH_LOG2 - 1);

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   accept_cnt_q, accept_cnt_d;
    logic [CNT_W-1:0]   term_cnt_q, term_cnt_d;
    logic               sat_q, sat_d;
    logic               v_q, v_d;
    logic [11:0]        p_q, p_d;
    logic               y_q, y_d;

    logic               accept;
    logic               accum;
    logic               out_xfer;
    logic [ACC_W-1:0]   tbl_ext;
    logic [ACC_W-1:0]   term;
    logic [ACC_W-1:0]   add_res;
    logic               add_ovf;
    logic signed [ACC_W-1:0] acc_s;
    logic [ACC_W-1:0]   acc_mean;

    // in_ready depends only on registered state; rst_n gating keeps it low during reset.
    assign in_ready  = rst_n && (state_q == ACCUM) && (accept_cnt_q < BATCH_N);
    assign out_valid = rst_n && (state_q == OUTPUT);
    assign accept    = in_valid && in_ready;
    assign accum     = v_q && (state_q == ACCUM);
    assign out_xfer  = out_valid && out_ready;

    assign tbl_addr  = rst_n ? (y_q ? p_q : ~p_q) : 12'd0;

    // Extend before negating so a -4096 table entry becomes +4096 without overflow.
    assign tbl_ext = {{(ACC_W-13){tbl_data[12]}}, tbl_data};
    assign term    = y_q ? tbl_ext : (~tbl_ext + 1'b1);

`ifdef CE_GRAD_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic [ACC_W:0] sum_ext;

    always_comb begin
        sum_ext = {acc_q[ACC_W-1], acc_q} + {term[ACC_W-1], term};
        add_ovf = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
        if (add_ovf) begin
            add_res = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            add_res = sum_ext[ACC_W-1:0];
        end
    end

    assign out_sat = out_valid && sat_q;
`else
    always_comb begin
        add_res = acc_q + term;
        add_ovf = 1'b0;
    end

    assign out_sat = 1'b0;
`endif

    assign acc_s    = acc_q;
    assign acc_mean = acc_s >>> BATCH_LOG2;
    assign out_grad = out_valid ? acc_mean : '0;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        accept_cnt_d = accept_cnt_q;
        term_cnt_d   = term_cnt_q;
        sat_d        = sat_q;
        v_d          = accept;
        p_d          = p_q;
        y_d          = y_q;

        if (accept) begin
            p_d          = in_p;
            y_d          = in_y;
            accept_cnt_d = accept_cnt_q + 1'b1;
        end

        if (accum) begin
            acc_d      = add_res;
            sat_d      = sat_q | add_ovf;
            term_cnt_d = term_cnt_q + 1'b1;
            if (term_cnt_q == LAST_TERM) begin
                state_d = OUTPUT;
            end
        end

        // Returning to ACCUM starts a fresh batch; nothing can be accepted in OUTPUT.
        if ((state_q == OUTPUT) && out_ready) begin
            state_d      = ACCUM;
            acc_d        = '0;
            accept_cnt_d = '0;
            term_cnt_d   = '0;
            sat_d        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ACCUM;
            acc_q        <= '0;
            accept_cnt_q <= '0;
            term_cnt_q   <= '0;
            sat_q        <= 1'b0;
            v_q          <= 1'b0;
            p_q          <= 12'd0;
            y_q          <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            accept_cnt_q <= accept_cnt_d;
            term_cnt_q   <= term_cnt_d;
            sat_q        <= sat_d;
            v_q          <= v_d;
            p_q          <= p_d;
            y_q          <= y_d;
        end
    end

    a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_grad)));

    a_no_accept_in_output: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> !in_ready);

    a_xfer_leaves_output: assert property (@(posedge clk) disable iff (!rst_n)
        out_xfer |=> !out_valid);

endmodule

// File: tb/tb_ce_grad_accum.sv
// Randomized bench for ce_grad_accum: a table model answers tbl_addr, and a batch-level
// gradient model predicts every batch-mean result, its sat flag and its timing.
module tb_ce_grad_accum;

    localparam int BATCH_LOG2 = 3;
    localparam int BATCH      = 1 << BATCH_LOG2;
    localparam int ACC_W      = 16;
    localparam int ACC_MAX    = (1 << (ACC_W - 1)) - 1;
    localparam int ACC_MIN    = -(1 << (ACC_W - 1));
    localparam int WAIT_BOUND = 500;

    logic                    clk;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [11:0]             in_p;
    logic                    in_y;
    logic [11:0]             tbl_addr;
    logic [12:0]             tbl_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_grad;
    logic                    out_sat;

    int n_checks = 0;
    int n_fail   = 0;
    int ready_mode;   // 0: always ready, 1: random, 2: hold low
    int n_batches = 0;
    int n_outs    = 0;

    int                 pend_q[$];
    logic [ACC_W-1:0]   exp_q[$];
    logic               exp_sat_q[$];

    ce_grad_accum #(.BATCH_LOG2(BATCH_LOG2), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_p      (in_p),
        .in_y      (in_y),
        .tbl_addr  (tbl_addr),
        .tbl_data  (tbl_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_grad  (out_grad),
        .out_sat   (out_sat)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference models ----------------
    // Reciprocal table: approximately -1/p in units of 1/4096, clamped at -4096.
    function automatic int tbl_model(input logic [11:0] a);
        int v;
        if (a == 12'd0) v = -4096;
        else v = -(4096 / int'(a));
        if (v < -4096) v = -4096;
        return v;
    endfunction

    assign tbl_data = 13'(tbl_model(tbl_addr));

    // dL/dp: -1/p for the target class, +1/(1-p) otherwise.
    function automatic int grad_model(input logic [11:0] p, input logic y);
        if (y) return tbl_model(p);
        return -tbl_model(12'd4095 - p);
    endfunction

    task automatic close_batch();
        int   sum;
        logic sat;
        logic signed [ACC_W-1:0] w;
        sum = 0;
        sat = 1'b0;
        foreach (pend_q[i]) begin
            sum += pend_q[i];
`ifdef CE_GRAD_SAT_EN
            if (sum > ACC_MAX) begin sum = ACC_MAX; sat = 1'b1; end
            if (sum < ACC_MIN) begin sum = ACC_MIN; sat = 1'b1; end
`else
            w   = sum[ACC_W-1:0];
            sum = int'(w);
`endif
        end
        exp_q.push_back(ACC_W'(sum >>> BATCH_LOG2));
        exp_sat_q.push_back(sat);
        pend_q.delete();
        n_batches++;
    endtask

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        addr_chk = 1'b0;
    logic [11:0] exp_addr;
    logic        ready_chk = 1'b0;
    int          lat_cnt = -1;
    logic        hold_vld = 1'b0;
    logic signed [ACC_W-1:0] hold_grad;

    always @(negedge clk) begin
        if (!rst_n) begin
            check_eq("rst_in_ready", in_ready, 0);
            check_eq("rst_out_valid", out_valid, 0);
            check_eq("rst_out_grad", out_grad, 0);
            check_eq("rst_out_sat", out_sat, 0);
            check_eq("rst_tbl_addr", tbl_addr, 0);
            pend_q.delete();
            addr_chk  = 1'b0;
            ready_chk = 1'b0;
            hold_vld  = 1'b0;
            lat_cnt   = -1;
        end else begin
            if (addr_chk) check_eq("tbl_addr", tbl_addr, exp_addr);
            addr_chk = 1'b0;
            if (ready_chk) check_eq("in_ready_after_out", in_ready, 1);
            ready_chk = 1'b0;
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 1) check_eq("out_valid_early", out_valid, 0);
                if (lat_cnt == 0) check_eq("out_latency", out_valid, 1);
            end
            if (out_valid) begin
                check_eq("in_ready_in_output", in_ready, 0);
                if (hold_vld) check_eq("grad_stable", out_grad, hold_grad);
                if (out_ready) begin
                    n_outs++;
                    check_eq("exp_q_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
                    if (exp_q.size() > 0) begin
                        check_eq("out_grad", out_grad, $signed(exp_q.pop_front()));
                        check_eq("out_sat", out_sat, exp_sat_q.pop_front());
                    end
                    ready_chk = 1'b1;
                    hold_vld  = 1'b0;
                end else begin
                    hold_vld  = 1'b1;
                    hold_grad = out_grad;
                end
            end else begin
                hold_vld = 1'b0;
            end
            if (in_valid && in_ready) begin
                pend_q.push_back(grad_model(in_p, in_y));
                addr_chk = 1'b1;
                exp_addr = in_y ? in_p : 12'd4095 - in_p;
                if (pend_q.size() == BATCH) begin
                    close_batch();
                    lat_cnt = 2;
                end
            end
        end
    end

    // ---------------- out_ready driver ----------------
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- input driver tasks ----------------
    task automatic send(input logic [11:0] p, input logic y, input int gap);
        int waited;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_p     = p;
        in_y     = y;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < WAIT_BOUND) begin
            @(negedge clk);
            waited++;
        end
        if (waited == WAIT_BOUND) check_eq("accept_timeout", waited, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_p     = $urandom_range(0, 4095);
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < WAIT_BOUND) begin
            @(posedge clk);
            c++;
        end
        #1;
        if (c == WAIT_BOUND) check_eq("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid();
        int c;
        c = 0;
        @(negedge clk);
        while (!out_valid && c < WAIT_BOUND) begin
            @(negedge clk);
            c++;
        end
        if (c == WAIT_BOUND) check_eq("out_valid_timeout", c, 0);
    endtask

    function automatic logic [11:0] pick_p();
        case ($urandom_range(0, 5))
            0:       return 12'd0;
            1:       return 12'd1;
            2:       return 12'd4095;
            default: return 12'($urandom_range(0, 4095));
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_p       = 12'd0;
        in_y       = 1'b0;
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // full-rate batch, table -2 every sample
        repeat (BATCH) send(12'd2048, 1'b1, 0);
        wait_drain();

        // opposing labels cancel
        for (int i = 0; i < BATCH / 2; i++) begin
            send(12'd2048, 1'b1, 0);
            send(12'd2048, 1'b0, $urandom_range(0, 2));
        end
        wait_drain();

        // +4096 terms push past the positive limit
        repeat (BATCH) send(12'd4095, 1'b0, 0);
        wait_drain();

        // -4096 terms land exactly on the negative limit
        repeat (BATCH) send(12'd1, 1'b1, 0);
        wait_drain();

        // backpressure in OUTPUT while the next batch is already offered
        ready_mode = 2;
        repeat (BATCH) send(pick_p(), 1'($urandom_range(0, 1)), 0);
        fork
            begin
                repeat (BATCH) send(12'd2048, 1'b1, 0);
            end
            begin
                wait_out_valid();
                repeat (5) @(posedge clk);
                #1;
                ready_mode = 0;
            end
        join
        wait_drain();

        // reset mid-batch discards partial work
        repeat (5) send(pick_p(), 1'($urandom_range(0, 1)), 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (BATCH) send(12'd2048, 1'b1, 0);
        wait_drain();

        // random batches with gaps and random backpressure
        ready_mode = 1;
        for (int b = 0; b < 8; b++) begin
            repeat (BATCH) send(pick_p(), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end
        ready_mode = 0;
        wait_drain();

        check_eq("outputs_seen", n_outs, n_batches);
        check_eq("exp_q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
